// File: rtl/seq_stage22_mask_mem_if.sv
// Bus bundle for seq_stage22_mask_mem: masked write ports, one read port,
// and collision status outputs.
interface seq_stage22_mask_mem_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_mask;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         rd_valid;
  logic                         wr_conflict;
  logic [CNT_WIDTH-1:0]         conflict_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_conflict, conflict_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    output rd_data, rd_valid, wr_conflict, conflict_cnt
  );
endinterface

// File: rtl/seq_stage22_mask_mem.sv
// Multi-port bit-masked write memory with one registered read port,
// optional read-after-write bypass and a saturating write-collision counter.
module seq_stage22_mask_mem #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          ADDR_WIDTH = 4,
  parameter int unsigned          DEPTH      = 16,
  parameter int unsigned          NUM_WR     = 2,
  parameter int unsigned          RD_BYPASS  = 0,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE = '0,
  parameter int unsigned          CNT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_stage22_mask_mem_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wa_c [NUM_WR];
  logic [DATA_WIDTH-1:0] wd_c [NUM_WR];
  logic [DATA_WIDTH-1:0] wm_c [NUM_WR];
  logic                  wv_c [NUM_WR];

  logic                  rd_in_rng_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  collision_c;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_conflict_q, wr_conflict_d;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;

  // Per-port unpack; a port only counts as writing when its address is in range
  always_comb begin
    for (int p = 0; p < int'(NUM_WR); p++) begin
      wa_c[p] = bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wd_c[p] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      wm_c[p] = bus.wr_mask[p*DATA_WIDTH +: DATA_WIDTH];
      wv_c[p] = bus.wr_en[p] && (32'(wa_c[p]) < DEPTH);
    end
  end

  // Bit-granular writes in ascending port order: later ports override shared bits
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (wv_c[p]) begin
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
          if (wm_c[p][i]) mem_q[wa_c[p]][i] <= wd_c[p][i];
        end
      end
    end
  end

  // Read word, optionally with this edge's writes merged in
  always_comb begin
    rd_in_rng_c = 32'(bus.rd_addr) < DEPTH;
    rd_word_c   = '0;
    if (rd_in_rng_c) begin
      rd_word_c = mem_q[bus.rd_addr];
      if (RD_BYPASS != 0) begin
        for (int p = 0; p < int'(NUM_WR); p++) begin
          if (wv_c[p] && (wa_c[p] == bus.rd_addr)) begin
            rd_word_c = (rd_word_c & ~wm_c[p]) | (wd_c[p] & wm_c[p]);
          end
        end
      end
    end
  end

  // Collision: any pair of active ports hitting overlapping bits of one word
  always_comb begin
    collision_c = 1'b0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      for (int q = p + 1; q < int'(NUM_WR); q++) begin
        if (wv_c[p] && wv_c[q] && (wa_c[p] == wa_c[q]) && ((wm_c[p] & wm_c[q]) != '0)) begin
          collision_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_d      = rd_data_q;
    rd_valid_d     = bus.rd_en;
    wr_conflict_d  = collision_c;
    conflict_cnt_d = conflict_cnt_q;
    if (bus.rd_en) rd_data_d = rd_word_c;
    if (collision_c && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q      <= RST_VALUE;
      rd_valid_q     <= 1'b0;
      wr_conflict_q  <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      wr_conflict_q  <= wr_conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wr_conflict  = wr_conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_seq_stage22_mask_mem.sv
// Bench for seq_stage22_mask_mem: two instances (no-bypass DEPTH=12 CNT_WIDTH=2,
// bypass DEPTH=16 CNT_WIDTH=8) driven identically and checked against a word-level model.
module tb_seq_stage22_mask_mem;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] wr_mask;
  logic        rd_en;
  logic [3:0]  rd_addr;

  seq_stage22_mask_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WR(2), .CNT_WIDTH(2)) bus0 ();
  seq_stage22_mask_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WR(2), .CNT_WIDTH(8)) bus1 ();

  seq_stage22_mask_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_WR(2),
    .RD_BYPASS(0), .RST_VALUE(8'h00), .CNT_WIDTH(2)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  seq_stage22_mask_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .NUM_WR(2),
    .RD_BYPASS(1), .RST_VALUE(8'h5A), .CNT_WIDTH(8)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
  assign bus0.wr_mask = wr_mask; assign bus1.wr_mask = wr_mask;
  assign bus0.rd_en = rd_en;   assign bus1.rd_en = rd_en;
  assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr;

  logic [7:0] rd_o  [2];
  logic       val_o [2];
  logic       cf_o  [2];
  logic [7:0] cnt_o [2];
  assign rd_o[0]  = bus0.rd_data;      assign rd_o[1]  = bus1.rd_data;
  assign val_o[0] = bus0.rd_valid;     assign val_o[1] = bus1.rd_valid;
  assign cf_o[0]  = bus0.wr_conflict;  assign cf_o[1]  = bus1.wr_conflict;
  assign cnt_o[0] = {6'b0, bus0.conflict_cnt};
  assign cnt_o[1] = bus1.conflict_cnt;

  // Reference model: parameters and state per instance
  int         depth_m [2] = '{12, 16};
  bit         byp_m   [2] = '{1'b0, 1'b1};
  int         cmax_m  [2] = '{3, 255};
  logic [7:0] rstv_m  [2] = '{8'h00, 8'h5A};
  logic [7:0] mem_m   [2][16];
  logic [7:0] exp_rd  [2];
  logic       exp_v   [2];
  logic       exp_c   [2];
  int         exp_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_rd[d]  = rstv_m[d];
      exp_v[d]   = 1'b0;
      exp_c[d]   = 1'b0;
      exp_cnt[d] = 0;
    end
  endtask

  task automatic model_edge();
    logic [7:0] nw [16];
    int a, b;
    bit coll;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) nw[k] = mem_m[d][k];
      for (int p = 0; p < 2; p++) begin
        a = int'(wr_addr[p*4 +: 4]);
        if (wr_en[p] && a < depth_m[d])
          nw[a] = (nw[a] & ~wr_mask[p*8 +: 8]) | (wr_data[p*8 +: 8] & wr_mask[p*8 +: 8]);
      end
      a = int'(wr_addr[3:0]);
      b = int'(wr_addr[7:4]);
      coll = wr_en[0] && wr_en[1] && (a == b) && (a < depth_m[d]) &&
             ((wr_mask[7:0] & wr_mask[15:8]) != 8'h00);
      if (rd_en) begin
        a = int'(rd_addr);
        if (a >= depth_m[d]) exp_rd[d] = 8'h00;
        else if (byp_m[d])   exp_rd[d] = nw[a];
        else                 exp_rd[d] = mem_m[d][a];
      end
      exp_v[d] = rd_en;
      exp_c[d] = coll;
      if (coll && exp_cnt[d] < cmax_m[d]) exp_cnt[d]++;
      for (int k = 0; k < 16; k++) mem_m[d][k] = nw[k];
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_rd_data", d),  32'(rd_o[d]),  32'(exp_rd[d]));
      check($sformatf("dut%0d_rd_valid", d), 32'(val_o[d]), 32'(exp_v[d]));
      check($sformatf("dut%0d_conflict", d), 32'(cf_o[d]),  32'(exp_c[d]));
      check($sformatf("dut%0d_cnt", d),      32'(cnt_o[d]), 32'(exp_cnt[d]));
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b0;  rd_addr = '0;
  endtask

  task automatic set_port(input int p, input logic [3:0] a, input logic [7:0] dt, input logic [7:0] m);
    wr_en[p] = 1'b1;
    wr_addr[p*4 +: 4] = a;
    wr_data[p*8 +: 8] = dt;
    wr_mask[p*8 +: 8] = m;
  endtask

  task automatic set_rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  // One clock: edge, model update, sample 1ns later, then clear inputs
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    idle();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int k = 0; k < 16; k++) mem_m[d][k] = 8'h00;
    idle();
    model_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_rd%0d", d),  32'(rd_o[d]),  32'(rstv_m[d]));
      check($sformatf("reset_cnt%0d", d), 32'(cnt_o[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Fill every word so later reads never see uninitialised storage
    for (int k = 0; k < 8; k++) begin
      set_port(0, 4'(2*k),     8'($urandom), 8'hFF);
      set_port(1, 4'(2*k + 1), 8'($urandom), 8'hFF);
      step();
    end

    // Disjoint masks merge, no collision
    set_port(0, 4'd3, 8'hAA, 8'hF0);
    set_port(1, 4'd3, 8'h55, 8'h0F);
    step();
    check("merge_conflict", 32'(cf_o[1]), 32'd0);
    set_rd(4'd3);
    step();
    check("merge_rd0", 32'(rd_o[0]), 32'hA5);
    check("merge_rd1", 32'(rd_o[1]), 32'hA5);

    // Full overlap: highest port wins, one collision
    set_port(0, 4'd5, 8'h11, 8'hFF);
    set_port(1, 4'd5, 8'h22, 8'hFF);
    step();
    check("lww_conflict", 32'(cf_o[0]), 32'd1);
    check("lww_cnt", 32'(cnt_o[1]), 32'd1);
    set_rd(4'd5);
    step();
    check("lww_rd", 32'(rd_o[0]), 32'h22);
    check("lww_conflict_drop", 32'(cf_o[1]), 32'd0);

    // Same-edge write and read of one word
    set_port(0, 4'd7, 8'h0F, 8'hFF);
    step();
    set_port(0, 4'd7, 8'hF0, 8'hFF);
    set_rd(4'd7);
    step();
    check("bypass0_rd", 32'(rd_o[0]), 32'h0F);
    check("bypass1_rd", 32'(rd_o[1]), 32'hF0);
    check("bypass_valid", 32'(val_o[0]), 32'd1);

    // Address 13: out of range for the 12-word instance only
    set_port(0, 4'd13, 8'h77, 8'hFF);
    step();
    set_rd(4'd13);
    step();
    check("oor_rd0", 32'(rd_o[0]), 32'h00);
    check("oor_rd1", 32'(rd_o[1]), 32'h77);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_rd0", 32'(rd_o[0]), 32'h00);
      check("hold_valid", 32'(val_o[0]), 32'd0);
    end

    // Asynchronous reset between edges; storage must survive
    set_port(0, 4'd2, 8'h3C, 8'hFF);
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_rd0", 32'(rd_o[0]), 32'h00);
    check("areset_rd1", 32'(rd_o[1]), 32'h5A);
    check("areset_cnt", 32'(cnt_o[1]), 32'd0);
    compare_all();
    #1 rst_n = 1'b1;
    set_rd(4'd2);
    step();
    check("after_reset_rd0", 32'(rd_o[0]), 32'h3C);
    check("after_reset_rd1", 32'(rd_o[1]), 32'h3C);

    // Five back-to-back collisions: the 2-bit counter sticks at 3
    for (int k = 0; k < 5; k++) begin
      set_port(0, 4'd1, 8'($urandom), 8'hFF);
      set_port(1, 4'd1, 8'($urandom), 8'h81);
      step();
      check("sat_cnt0", 32'(cnt_o[0]), 32'((k + 1 > 3) ? 3 : k + 1));
      check("sat_cnt1", 32'(cnt_o[1]), 32'(k + 1));
      check("sat_conflict", 32'(cf_o[0]), 32'd1);
    end

    // Random traffic concentrated on a few addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          set_port(p,
                   ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                   8'($urandom),
                   ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        end
      end
      if ($urandom_range(0, 2) != 0) set_rd(4'($urandom_range(0, 15)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_stage22_mask_mem.md
Name: seq_stage22_mask_mem

Overview:
Parametrised multi-port memory with per-port bit-masked writes and one synchronous read port. It is the next-generation memory-inference elaboration target, generalising fixed 8x16, single-word-port plus single-bit-port storage to N masked write ports. It adds optional read-after-write bypass, a registered write-collision detector and a saturating collision counter. It exercises multi-port memory extraction, enable/mask ports and async-reset registers together in one always_ff.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_WIDTH, 4, address bits per port
DEPTH, 16, number of words; legal range 1 .. 2**ADDR_WIDTH
NUM_WR, 2, number of write ports; must be 1 or more
RD_BYPASS, 0, 0 = read returns pre-write contents; 1 = read returns post-write contents of the same edge
RST_VALUE, '0, reset value of rd_data (DATA_WIDTH bits)
CNT_WIDTH, 8, width of the collision counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  NUM_WR  per-port write enable; bit p belongs to port p
wr_addr  in  NUM_WR*ADDR_WIDTH  port p address in slice [p*ADDR_WIDTH +: ADDR_WIDTH]
wr_data  in  NUM_WR*DATA_WIDTH  port p data in slice [p*DATA_WIDTH +: DATA_WIDTH]
wr_mask  in  NUM_WR*DATA_WIDTH  port p bit mask; 1 = write that bit
rd_en  in  1  read enable
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  high for one cycle after each enabled read
wr_conflict  out  1  registered collision flag
conflict_cnt  out  CNT_WIDTH  saturating count of collision cycles

Behaviour:
- Reset (rst_n low, asynchronous): rd_data=RST_VALUE, rd_valid=0, wr_conflict=0, conflict_cnt=0.
- Memory array is not reset. Contents survive rst_n assertion; never-written words are X.
- Write, at each posedge:
  - Ports are evaluated in ascending index p. If wr_en[p]=1 and wr_addr_p < DEPTH, each bit i with wr_mask_p[i]=1 takes wr_data_p[i].
  - Bits with mask 0 hold their value.
  - Overlapping bits at the same address: the highest-index port wins (last write wins). Non-overlapping masked bits from different ports merge.
- Out-of-range write (wr_addr_p >= DEPTH): dropped silently. Other ports still write.
- Read, 1-cycle latency:
  - On a posedge with rd_en=1, rd_data is loaded from mem[rd_addr].
  - RD_BYPASS=0: value before this edge's writes.
  - RD_BYPASS=1: value after this edge's merged writes, including all port merging.
  - rd_en=0: rd_data holds its previous value.
  - rd_addr >= DEPTH: rd_data loads all zeros.
- rd_valid is loaded with rd_en every cycle.
- Collision detection:
  - A collision cycle is one where two or more ports have wr_en=1, the same in-range address, and a nonzero AND of their masks.
  - wr_conflict is registered: high on the cycle after a collision cycle, low otherwise.
  - conflict_cnt increments by 1 per collision cycle and saturates at 2**CNT_WIDTH-1; no wrap.
- Reset released mid-operation: the first posedge with rst_n high performs normal writes and reads. rd_valid is driven by rd_en from that edge only.
- NUM_WR=1: no collision is possible; wr_conflict and conflict_cnt stay 0.

Test Plan:
- Masked merge: NUM_WR=2. Port0 writes addr 3 data 0xAA mask 0xF0; port1 writes addr 3 data 0x55 mask 0x0F, same edge. Next cycle rd_en, addr 3 -> rd_data=0xA5, wr_conflict stays 0, conflict_cnt=0.
- Last-write-wins: both ports write addr 5, mask 0xFF, data 0x11 and 0x22. Read addr 5 -> 0x22; wr_conflict=1 for exactly one cycle; conflict_cnt=1.
- Bypass modes: mem[7]=0x0F, then write 0xF0 to addr 7 with rd_en and rd_addr=7 on the same edge.
  - RD_BYPASS=0 -> rd_data=0x0F.
  - RD_BYPASS=1 -> rd_data=0xF0.
  - rd_valid=1 one cycle in both.
- Hold and out-of-range: DEPTH=12. Write addr 13 data 0x77, then read addr 13 -> rd_data=0x00. Then rd_en=0 for 3 cycles -> rd_data holds 0x00, rd_valid=0.
- Async reset mid-run: after writing addr 2=0x3C, pulse rst_n low between edges. rd_data=RST_VALUE and conflict_cnt=0 immediately, without a clock edge. After release, read addr 2 -> 0x3C (memory preserved).
- Saturation: CNT_WIDTH=2, collisions on 5 consecutive cycles -> conflict_cnt goes 1,2,3,3,3 and wr_conflict stays high through all five.
